// File: rtl/stage_ma.sv
// Memory-access stage: issues one data-memory request per load/store and formats load data for write-back.
// Latency 1 cycle for non-memory ops, minimum 2 cycles for memory ops; stalls upstream until the memory acks.
module stage_ma #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ma_valid,
    input  logic [WIDTH-1:0] i_ma_pc,
    input  logic [WIDTH-1:0] i_ma_alu_rslt,
    input  logic [WIDTH-1:0] i_ma_store_data,
    input  logic [3:0]       i_ma_mem_cntrl,
    input  logic             i_ma_mem_sext,
    input  logic [2:0]       i_ma_wb_cntrl,
    input  logic [4:0]       i_ma_rdst,
    output logic             o_dmem_req,
    output logic             o_dmem_we,
    output logic [3:0]       o_dmem_be,
    output logic [WIDTH-1:0] o_dmem_addr,
    output logic [WIDTH-1:0] o_dmem_wdata,
    input  logic             i_dmem_ack,
    input  logic [WIDTH-1:0] i_dmem_rdata,
    output logic             o_ma_stall,
    output logic             o_ma_misalign,
    output logic             o_ma_valid,
    output logic [WIDTH-1:0] o_ma_pc,
    output logic [WIDTH-1:0] o_ma_data_o_ma,
    output logic [WIDTH-1:0] o_ma_alu_rslt,
    output logic [2:0]       o_ma_cntrl,
    output logic [4:0]       o_ma_rdst
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [3:0]       be_q;
    logic             we_q;
    logic [1:0]       size_q;
    logic             sext_q;

    logic [1:0]       size;
    logic             mem_op;
    logic             misaligned;
    logic             issue;
    logic             done;
    logic             ld_instr;
    logic [3:0]       be_calc;
    logic [WIDTH-1:0] wdata_calc;
    logic [WIDTH-1:0] lane;
    logic [WIDTH-1:0] load_fmt;

    assign size       = i_ma_mem_cntrl[3:2];
    assign mem_op     = |i_ma_mem_cntrl[1:0];
    assign misaligned = ((size == 2'b01) && i_ma_alu_rslt[0]) ||
                        (size[1] && (i_ma_alu_rslt[1:0] != 2'b00));
    assign issue      = (state == IDLE) && i_ma_valid && mem_op && !misaligned;
    assign done       = (state == BUSY) && i_dmem_ack;
    assign ld_instr   = ((state == IDLE) && i_ma_valid && !mem_op) || done;

    // Reset gating keeps stall low even while EX presents a memory op during reset.
    assign o_ma_stall = rst && (issue || ((state == BUSY) && !i_dmem_ack));

    assign o_dmem_req   = (state == BUSY);
    assign o_dmem_we    = o_dmem_req && we_q;
    assign o_dmem_be    = o_dmem_req ? be_q : 4'b0000;
    assign o_dmem_addr  = {addr_q[WIDTH-1:2], 2'b00};
    assign o_dmem_wdata = wdata_q;

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = i_ma_store_data;
        case (size)
            2'b00: begin
                be_calc    = 4'b0001 << i_ma_alu_rslt[1:0];
                wdata_calc = {(WIDTH/8){i_ma_store_data[7:0]}};
            end
            2'b01: begin
                be_calc    = i_ma_alu_rslt[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {(WIDTH/16){i_ma_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        lane     = i_dmem_rdata >> {addr_q[1:0], 3'b000};
        load_fmt = i_dmem_rdata;
        case (size_q)
            2'b00: load_fmt = {{(WIDTH-8){sext_q & lane[7]}}, lane[7:0]};
            2'b01: load_fmt = {{(WIDTH-16){sext_q & lane[15]}}, lane[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            be_q           <= 4'b0000;
            we_q           <= 1'b0;
            size_q         <= 2'b00;
            sext_q         <= 1'b0;
            o_ma_misalign  <= 1'b0;
            o_ma_valid     <= 1'b0;
            o_ma_pc        <= '0;
            o_ma_data_o_ma <= '0;
            o_ma_alu_rslt  <= '0;
            o_ma_cntrl     <= 3'b000;
            o_ma_rdst      <= 5'd0;
        end else begin
            o_ma_misalign <= (state == IDLE) && i_ma_valid && mem_op && misaligned;
            if (issue) begin
                state   <= BUSY;
                addr_q  <= i_ma_alu_rslt;
                wdata_q <= wdata_calc;
                be_q    <= be_calc;
                we_q    <= i_ma_mem_cntrl[1];
                size_q  <= size;
                sext_q  <= i_ma_mem_sext;
            end else if (done) begin
                state <= IDLE;
            end
            // Anything that is not a completing instruction becomes a bubble.
            if (ld_instr) begin
                o_ma_valid     <= 1'b1;
                o_ma_pc        <= i_ma_pc;
                o_ma_data_o_ma <= (done && !we_q) ? load_fmt : '0;
                o_ma_alu_rslt  <= i_ma_alu_rslt;
                o_ma_cntrl     <= i_ma_wb_cntrl;
                o_ma_rdst      <= i_ma_rdst;
            end else begin
                o_ma_valid     <= 1'b0;
                o_ma_pc        <= '0;
                o_ma_data_o_ma <= '0;
                o_ma_alu_rslt  <= '0;
                o_ma_cntrl     <= 3'b000;
                o_ma_rdst      <= 5'd0;
            end
        end
    end

endmodule

// File: tb/tb_stage_ma.sv
// Table-driven bench for stage_ma with a scoreboard queue of expected write-back records.
module tb_stage_ma;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_ma_valid = 1'b0;
    logic [31:0] i_ma_pc = '0, i_ma_alu_rslt = '0, i_ma_store_data = '0;
    logic [3:0]  i_ma_mem_cntrl = '0;
    logic        i_ma_mem_sext = 1'b0;
    logic [2:0]  i_ma_wb_cntrl = '0;
    logic [4:0]  i_ma_rdst = '0;
    logic        o_dmem_req, o_dmem_we;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_addr, o_dmem_wdata;
    logic        i_dmem_ack = 1'b0;
    logic [31:0] i_dmem_rdata = '0;
    logic        o_ma_stall, o_ma_misalign, o_ma_valid;
    logic [31:0] o_ma_pc, o_ma_data_o_ma, o_ma_alu_rslt;
    logic [2:0]  o_ma_cntrl;
    logic [4:0]  o_ma_rdst;

    stage_ma #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .i_ma_valid(i_ma_valid), .i_ma_pc(i_ma_pc), .i_ma_alu_rslt(i_ma_alu_rslt),
        .i_ma_store_data(i_ma_store_data), .i_ma_mem_cntrl(i_ma_mem_cntrl),
        .i_ma_mem_sext(i_ma_mem_sext), .i_ma_wb_cntrl(i_ma_wb_cntrl), .i_ma_rdst(i_ma_rdst),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_be(o_dmem_be),
        .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
        .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
        .o_ma_stall(o_ma_stall), .o_ma_misalign(o_ma_misalign),
        .o_ma_valid(o_ma_valid), .o_ma_pc(o_ma_pc), .o_ma_data_o_ma(o_ma_data_o_ma),
        .o_ma_alu_rslt(o_ma_alu_rslt), .o_ma_cntrl(o_ma_cntrl), .o_ma_rdst(o_ma_rdst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] pc, alu, sdata;
        logic [3:0]  mc;
        logic        sext;
        logic [2:0]  wb;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          ack_dly;
        logic        ack_idle;
        logic        exp_mis;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        logic [31:0] pc, alu, data;
        logic [2:0]  cntrl;
        logic [4:0]  rdst;
        logic        chk_data;
    } exp_t;

    vec_t vecs[13];
    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic is_mem;
        exp_t e, got;
        is_mem = v.valid && (v.mc[1:0] != 2'b00) && !v.exp_mis;
        i_ma_valid      = v.valid;
        i_ma_pc         = v.pc;
        i_ma_alu_rslt   = v.alu;
        i_ma_store_data = v.sdata;
        i_ma_mem_cntrl  = v.mc;
        i_ma_mem_sext   = v.sext;
        i_ma_wb_cntrl   = v.wb;
        i_ma_rdst       = v.rd;
        i_dmem_ack      = v.ack_idle;
        i_dmem_rdata    = 32'h0;
        if (v.valid && !v.exp_mis)
            sb.push_back('{v.pc, v.alu, v.exp_data, v.wb, v.rd, is_mem});
        #1;
        check($sformatf("v%0d idle_req", idx), {31'b0, o_dmem_req}, 32'd0);
        if (is_mem) begin
            check($sformatf("v%0d stall_issue", idx), {31'b0, o_ma_stall}, 32'd1);
            @(posedge clk); #1;
            i_dmem_ack = 1'b0;
            check($sformatf("v%0d req", idx), {31'b0, o_dmem_req}, 32'd1);
            check($sformatf("v%0d addr", idx), o_dmem_addr, v.alu & 32'hFFFF_FFFC);
            check($sformatf("v%0d be", idx), {28'b0, o_dmem_be}, {28'b0, v.exp_be});
            check($sformatf("v%0d we", idx), {31'b0, o_dmem_we}, {31'b0, v.mc[1]});
            if (v.mc[1])
                check($sformatf("v%0d wdata", idx), o_dmem_wdata, v.exp_wdata);
            check($sformatf("v%0d bubble0", idx), {31'b0, o_ma_valid}, 32'd0);
            for (int i = 0; i < v.ack_dly; i++) begin
                #1;
                check($sformatf("v%0d stall_wait%0d", idx, i), {31'b0, o_ma_stall}, 32'd1);
                @(posedge clk); #1;
                check($sformatf("v%0d bubble_valid%0d", idx, i), {31'b0, o_ma_valid}, 32'd0);
                check($sformatf("v%0d bubble_cntrl%0d", idx, i), {29'b0, o_ma_cntrl}, 32'd0);
                check($sformatf("v%0d held_be%0d", idx, i), {28'b0, o_dmem_be}, {28'b0, v.exp_be});
            end
            i_dmem_ack   = 1'b1;
            i_dmem_rdata = v.rdata;
            #1;
            check($sformatf("v%0d stall_ack", idx), {31'b0, o_ma_stall}, 32'd0);
        end else begin
            check($sformatf("v%0d no_stall", idx), {31'b0, o_ma_stall}, 32'd0);
        end
        @(posedge clk); #1;
        i_dmem_ack   = 1'b0;
        i_dmem_rdata = 32'h0;
        check($sformatf("v%0d misalign", idx), {31'b0, o_ma_misalign}, {31'b0, v.exp_mis});
        check($sformatf("v%0d req_after", idx), {31'b0, o_dmem_req}, 32'd0);
        if (o_ma_valid) begin
            if (sb.size() == 0) begin
                check($sformatf("v%0d unexpected_out", idx), 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                got.pc = o_ma_pc;
                check($sformatf("v%0d pc", idx), got.pc, e.pc);
                check($sformatf("v%0d alu", idx), o_ma_alu_rslt, e.alu);
                check($sformatf("v%0d cntrl", idx), {29'b0, o_ma_cntrl}, {29'b0, e.cntrl});
                check($sformatf("v%0d rdst", idx), {27'b0, o_ma_rdst}, {27'b0, e.rdst});
                if (e.chk_data)
                    check($sformatf("v%0d data", idx), o_ma_data_o_ma, e.data);
            end
        end else begin
            check($sformatf("v%0d out_valid", idx), 32'd0, {31'b0, sb.size() != 0});
            check($sformatf("v%0d bubble_cntrl", idx), {29'b0, o_ma_cntrl}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //          valid pc           alu           sdata         mc       sext wb      rd     rdata         dly ai   mis  be       wdata         data
        vecs[0]  = '{1'b1, 32'h40, 32'h0000_1234, 32'h0,        4'b0000, 1'b0, 3'b101, 5'd7,  32'h0,        0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0};
        vecs[1]  = '{1'b1, 32'h44, 32'hCAFE_0000, 32'h0,        4'b0000, 1'b0, 3'b100, 5'd31, 32'h0,        0, 1'b1, 1'b0, 4'b0000, 32'h0,        32'h0};
        vecs[2]  = '{1'b1, 32'h48, 32'h0000_0100, 32'h0,        4'b1001, 1'b0, 3'b101, 5'd3,  32'hDEADBEEF, 3, 1'b0, 1'b0, 4'b1111, 32'h0,        32'hDEADBEEF};
        vecs[3]  = '{1'b1, 32'h4C, 32'h0000_0103, 32'h0,        4'b0001, 1'b1, 3'b101, 5'd4,  32'h80FF_FF00, 0, 1'b0, 1'b0, 4'b1000, 32'h0,       32'hFFFF_FF80};
        vecs[4]  = '{1'b1, 32'h50, 32'h0000_0103, 32'h0,        4'b0001, 1'b0, 3'b101, 5'd5,  32'h80FF_FF00, 1, 1'b0, 1'b0, 4'b1000, 32'h0,       32'h0000_0080};
        vecs[5]  = '{1'b1, 32'h54, 32'h0000_0202, 32'h0000_ABCD, 4'b0110, 1'b0, 3'b000, 5'd0, 32'h0,        2, 1'b0, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0};
        vecs[6]  = '{1'b1, 32'h58, 32'h0000_0101, 32'h0,        4'b1001, 1'b0, 3'b101, 5'd6,  32'h0,        0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[7]  = '{1'b1, 32'h5C, 32'h0000_0102, 32'h0,        4'b0101, 1'b1, 3'b101, 5'd8,  32'h8001_1234, 1, 1'b0, 1'b0, 4'b1100, 32'h0,       32'hFFFF_8001};
        vecs[8]  = '{1'b1, 32'h60, 32'h0000_0101, 32'h0,        4'b0101, 1'b0, 3'b101, 5'd9,  32'h0,        0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[9]  = '{1'b1, 32'h64, 32'h0000_0301, 32'h0000_00A5, 4'b0010, 1'b0, 3'b000, 5'd0, 32'h0,        0, 1'b0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0};
        vecs[10] = '{1'b1, 32'h68, 32'h0000_0400, 32'h1234_5678, 4'b1011, 1'b0, 3'b000, 5'd0, 32'hFFFF_FFFF, 1, 1'b0, 1'b0, 4'b1111, 32'h1234_5678, 32'h0};
        vecs[11] = '{1'b0, 32'h6C, 32'h0000_0100, 32'h0,        4'b1001, 1'b0, 3'b101, 5'd10, 32'h0,        0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0};
        vecs[12] = '{1'b1, 32'h70, 32'h0000_0100, 32'h0,        4'b0101, 1'b0, 3'b110, 5'd11, 32'h1234_F00D, 0, 1'b0, 1'b0, 4'b0011, 32'h0,       32'h0000_F00D};

        // Reset with a load presented: everything must stay quiet.
        i_ma_valid = 1'b1; i_ma_mem_cntrl = 4'b1001; i_ma_alu_rslt = 32'h100;
        #12;
        check("rst_stall", {31'b0, o_ma_stall}, 32'd0);
        check("rst_req", {31'b0, o_dmem_req}, 32'd0);
        check("rst_valid", {31'b0, o_ma_valid}, 32'd0);
        check("rst_misalign", {31'b0, o_ma_misalign}, 32'd0);
        check("rst_pc", o_ma_pc, 32'd0);
        i_ma_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 13; k++) run_vec(k, vecs[k]);

        // Reset in the middle of a BUSY access, ack arriving afterwards.
        i_ma_valid = 1'b1; i_ma_pc = 32'h80; i_ma_alu_rslt = 32'h500;
        i_ma_mem_cntrl = 4'b1001; i_ma_wb_cntrl = 3'b101; i_ma_rdst = 5'd12;
        @(posedge clk); #1;
        check("mid_busy_req", {31'b0, o_dmem_req}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_req", {31'b0, o_dmem_req}, 32'd0);
        check("mid_rst_stall", {31'b0, o_ma_stall}, 32'd0);
        check("mid_rst_be", {28'b0, o_dmem_be}, 32'd0);
        i_ma_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        i_dmem_ack = 1'b1; i_dmem_rdata = 32'h5555_AAAA;
        #1;
        check("late_ack_stall", {31'b0, o_ma_stall}, 32'd0);
        @(posedge clk); #1;
        i_dmem_ack = 1'b0;
        check("late_ack_req", {31'b0, o_dmem_req}, 32'd0);
        check("late_ack_valid", {31'b0, o_ma_valid}, 32'd0);
        check("late_ack_data", o_ma_data_o_ma, 32'd0);
        @(posedge clk); #1;
        check("late_ack_valid2", {31'b0, o_ma_valid}, 32'd0);
        check("sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
